// File: rtl/stereo_pkg.sv
// Shared stereo-geometry constants and state type, used by both the
// depth-to-disparity and disparity-to-depth paths.
package stereo_pkg;

  localparam int unsigned PARALLAX_SCALE_DEFAULT   = 2973;
  localparam int unsigned RESOLUTION_WIDTH_DEFAULT = 1280;

  localparam int COORD_W    = 12;
  localparam int DEPTH_W    = 8;
  localparam int DIVIDEND_W = 16;
  localparam int ITER_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } proj_state_t;

endpackage

// File: rtl/depth_to_disparity_if.sv
// Request/response bundle for depth_to_disparity; master drives requests,
// slave (the converter) drives results and handshake status.
interface depth_to_disparity_if;
  import stereo_pkg::*;

  logic               data_valid_in;
  logic [DEPTH_W-1:0] depth_in;
  logic [COORD_W-1:0] x_1_in;
  logic [COORD_W-1:0] disparity_out;
  logic [COORD_W-1:0] x_2_out;
  logic               data_valid_out;
  logic               busy_out;
  logic               saturated_out;
  logic               clamped_out;

  modport master (
    output data_valid_in, depth_in, x_1_in,
    input  disparity_out, x_2_out, data_valid_out, busy_out,
           saturated_out, clamped_out
  );

  modport slave (
    input  data_valid_in, depth_in, x_1_in,
    output disparity_out, x_2_out, data_valid_out, busy_out,
           saturated_out, clamped_out
  );

endinterface

// File: rtl/serial_restoring_divider.sv
// 16-bit restoring divider, one quotient bit per step, MSB first. A zero
// divisor still takes all steps (no subtractions) and reports 4095.
module serial_restoring_divider
  import stereo_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_in,
  input  logic                  step_in,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DEPTH_W-1:0]    divisor_in,
  output logic [DIVIDEND_W-1:0] quotient_out,
  output logic                  div_zero_out,
  output logic                  last_out
);

  logic [ITER_W-1:0]     cnt_q, cnt_d;
  logic [DIVIDEND_W:0]   rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DEPTH_W-1:0]    divisor_q, divisor_d;
  logic                  zero_q, zero_d;
  logic [DIVIDEND_W+1:0] shifted;

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    zero_d    = zero_q;
    shifted   = {rem_q, quo_q[DIVIDEND_W-1]};
    if (load_in) begin
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = dividend_in;
      divisor_d = divisor_in;
      zero_d    = (divisor_in == '0);
    end else if (step_in) begin
      cnt_d = cnt_q + 1'b1;
      // Zero divisor skips the trial subtraction so timing is unchanged.
      if (!zero_q && (shifted >= {{(DIVIDEND_W+2-DEPTH_W){1'b0}}, divisor_q})) begin
        rem_d = shifted[DIVIDEND_W:0] - {{(DIVIDEND_W+1-DEPTH_W){1'b0}}, divisor_q};
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DIVIDEND_W:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      zero_q    <= zero_d;
    end
  end

  assign quotient_out = zero_q ? DIVIDEND_W'((1 << COORD_W) - 1) : quo_q;
  assign div_zero_out = zero_q;
  assign last_out     = (cnt_q == '1);

endmodule

// File: rtl/depth_to_disparity.sv
// Converts a target depth and left-camera x into disparity and right-camera x.
// Define DEPTH_TO_DISP_ROUND_EN for round-to-nearest disparity (default truncates).
//
// state  | meaning
// IDLE   | waiting for a request, outputs holding last result
// DIVIDE | divider stepping, 16 cycles
// FINISH | saturate, clamp, register results, pulse valid
module depth_to_disparity
  import stereo_pkg::*;
#(
  parameter int unsigned PARALLAX_SCALE   = PARALLAX_SCALE_DEFAULT,
  parameter int unsigned RESOLUTION_WIDTH = RESOLUTION_WIDTH_DEFAULT
) (
  input logic                 clk_in,
  input logic                 rst_in,
  depth_to_disparity_if.slave bus
);

  localparam logic [COORD_W-1:0]    X_MAX    = COORD_W'(RESOLUTION_WIDTH - 1);
  localparam logic [DIVIDEND_W-1:0] DISP_MAX = DIVIDEND_W'((1 << COORD_W) - 1);

  proj_state_t state_q, state_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COORD_W-1:0] disp_q, disp_d;
  logic [COORD_W-1:0] x2_q, x2_d;
  logic               dv_q, dv_d;
  logic               sat_q, sat_d;
  logic               clamp_q, clamp_d;

  logic                  div_load, div_step, div_last, div_zero;
  logic [DIVIDEND_W-1:0] dividend, quotient;
  logic                  quo_sat;
  logic [COORD_W-1:0]    disp_val;
  logic signed [COORD_W:0] x2_wide;

`ifdef DEPTH_TO_DISP_ROUND_EN
  assign dividend = DIVIDEND_W'(PARALLAX_SCALE) + DIVIDEND_W'(bus.depth_in >> 1);
`else
  assign dividend = DIVIDEND_W'(PARALLAX_SCALE);
`endif

  serial_restoring_divider u_div (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load_in      (div_load),
    .step_in      (div_step),
    .dividend_in  (dividend),
    .divisor_in   (bus.depth_in),
    .quotient_out (quotient),
    .div_zero_out (div_zero),
    .last_out     (div_last)
  );

  always_comb begin
    quo_sat  = div_zero || (quotient > DISP_MAX);
    disp_val = quo_sat ? '1 : quotient[COORD_W-1:0];
    x2_wide  = $signed({1'b0, x1_q}) - $signed({1'b0, disp_val});
  end

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    disp_d   = disp_q;
    x2_d     = x2_q;
    dv_d     = 1'b0;
    sat_d    = sat_q;
    clamp_d  = clamp_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_valid_in) begin
          div_load = 1'b1;
          x1_d     = bus.x_1_in;
          state_d  = DIVIDE;
        end
      end
      DIVIDE: begin
        div_step = 1'b1;
        if (div_last) state_d = FINISH;
      end
      FINISH: begin
        disp_d  = disp_val;
        sat_d   = quo_sat;
        clamp_d = 1'b0;
        x2_d    = x2_wide[COORD_W-1:0];
        if (x2_wide[COORD_W]) begin
          x2_d    = '0;
          clamp_d = 1'b1;
        end else if (x2_wide[COORD_W-1:0] > X_MAX) begin
          x2_d    = X_MAX;
          clamp_d = 1'b1;
        end
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      x1_q    <= '0;
      disp_q  <= '0;
      x2_q    <= '0;
      dv_q    <= 1'b0;
      sat_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      disp_q  <= disp_d;
      x2_q    <= x2_d;
      dv_q    <= dv_d;
      sat_q   <= sat_d;
      clamp_q <= clamp_d;
    end
  end

  assign bus.disparity_out  = disp_q;
  assign bus.x_2_out        = x2_q;
  assign bus.data_valid_out = dv_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.saturated_out  = sat_q;
  assign bus.clamped_out    = clamp_q;

endmodule

// File: tb/tb_depth_to_disparity.sv
// Directed self-checking bench for depth_to_disparity (both rounding builds).
module tb_depth_to_disparity;
  import stereo_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   failures = 0;

  depth_to_disparity_if bus ();

  depth_to_disparity dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

`ifdef DEPTH_TO_DISP_ROUND_EN
  localparam int EXP_D12  = 248;
  localparam int EXP_X12  = 392;
  localparam int EXP_D255 = 12;
  localparam int EXP_X255 = 1267;
  localparam int EXP_D6   = 496;
  localparam int EXP_X6   = 144;
`else
  localparam int EXP_D12  = 247;
  localparam int EXP_X12  = 393;
  localparam int EXP_D255 = 11;
  localparam int EXP_X255 = 1268;
  localparam int EXP_D6   = 495;
  localparam int EXP_X6   = 145;
`endif

  task automatic send(input logic [7:0] d, input logic [11:0] x);
    @(negedge clk_in);
    bus.data_valid_in = 1'b1;
    bus.depth_in      = d;
    bus.x_1_in        = x;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.data_valid_out !== 1'b1 && cyc < 40) begin
      @(negedge clk_in);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++; if (bus.disparity_out !== 12'd0) begin failures++; $display("FAIL reset_disp got=%0d exp=0", bus.disparity_out); end
    checks++; if (bus.x_2_out !== 12'd0) begin failures++; $display("FAIL reset_x2 got=%0d exp=0", bus.x_2_out); end
    checks++; if (bus.data_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
    checks++; if (bus.saturated_out !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", bus.saturated_out); end
    checks++; if (bus.clamped_out !== 1'b0) begin failures++; $display("FAIL reset_clamp got=%b exp=0", bus.clamped_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    send(8'd12, 12'd640);
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy_out); end
    wait_valid(lat);
    checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (bus.disparity_out !== 12'(EXP_D12)) begin failures++; $display("FAIL basic_disp got=%0d exp=%0d", bus.disparity_out, EXP_D12); end
    checks++; if (bus.x_2_out !== 12'(EXP_X12)) begin failures++; $display("FAIL basic_x2 got=%0d exp=%0d", bus.x_2_out, EXP_X12); end
    checks++; if (bus.saturated_out !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", bus.saturated_out); end
    checks++; if (bus.clamped_out !== 1'b0) begin failures++; $display("FAIL basic_clamp got=%b exp=0", bus.clamped_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL basic_busy_at_valid got=%b exp=0", bus.busy_out); end
    @(negedge clk_in);
    checks++; if (bus.data_valid_out !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", bus.data_valid_out); end
    checks++; if (bus.disparity_out !== 12'(EXP_D12)) begin failures++; $display("FAIL basic_hold got=%0d exp=%0d", bus.disparity_out, EXP_D12); end
  endtask

  task automatic test_far();
    int lat;
    send(8'd255, 12'd1279);
    wait_valid(lat);
    checks++; if (lat !== 17) begin failures++; $display("FAIL far_latency got=%0d exp=17", lat); end
    checks++; if (bus.disparity_out !== 12'(EXP_D255)) begin failures++; $display("FAIL far_disp got=%0d exp=%0d", bus.disparity_out, EXP_D255); end
    checks++; if (bus.x_2_out !== 12'(EXP_X255)) begin failures++; $display("FAIL far_x2 got=%0d exp=%0d", bus.x_2_out, EXP_X255); end
    checks++; if (bus.clamped_out !== 1'b0) begin failures++; $display("FAIL far_clamp got=%b exp=0", bus.clamped_out); end
  endtask

  task automatic test_clamp();
    int lat;
    send(8'd1, 12'd100);
    wait_valid(lat);
    checks++; if (bus.disparity_out !== 12'd2973) begin failures++; $display("FAIL clamp_disp got=%0d exp=2973", bus.disparity_out); end
    checks++; if (bus.x_2_out !== 12'd0) begin failures++; $display("FAIL clamp_x2 got=%0d exp=0", bus.x_2_out); end
    checks++; if (bus.clamped_out !== 1'b1) begin failures++; $display("FAIL clamp_flag got=%b exp=1", bus.clamped_out); end
    checks++; if (bus.saturated_out !== 1'b0) begin failures++; $display("FAIL clamp_sat got=%b exp=0", bus.saturated_out); end
  endtask

  task automatic test_depth_zero();
    int lat;
    send(8'd0, 12'd500);
    wait_valid(lat);
    checks++; if (lat !== 17) begin failures++; $display("FAIL zero_latency got=%0d exp=17", lat); end
    checks++; if (bus.disparity_out !== 12'd4095) begin failures++; $display("FAIL zero_disp got=%0d exp=4095", bus.disparity_out); end
    checks++; if (bus.x_2_out !== 12'd0) begin failures++; $display("FAIL zero_x2 got=%0d exp=0", bus.x_2_out); end
    checks++; if (bus.saturated_out !== 1'b1) begin failures++; $display("FAIL zero_sat got=%b exp=1", bus.saturated_out); end
    checks++; if (bus.clamped_out !== 1'b1) begin failures++; $display("FAIL zero_clamp got=%b exp=1", bus.clamped_out); end
  endtask

  task automatic test_busy_drop();
    int lat;
    send(8'd12, 12'd640);
    repeat (4) @(negedge clk_in);
    bus.data_valid_in = 1'b1;
    bus.depth_in      = 8'd6;
    bus.x_1_in        = 12'd640;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
    wait_valid(lat);
    checks++; if ((lat + 5) !== 17) begin failures++; $display("FAIL drop_latency got=%0d exp=17", lat + 5); end
    checks++; if (bus.disparity_out !== 12'(EXP_D12)) begin failures++; $display("FAIL drop_disp_a got=%0d exp=%0d", bus.disparity_out, EXP_D12); end
    bus.data_valid_in = 1'b1;
    bus.depth_in      = 8'd6;
    bus.x_1_in        = 12'd640;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy_out); end
    wait_valid(lat);
    checks++; if (lat !== 17) begin failures++; $display("FAIL b2b_latency got=%0d exp=17", lat); end
    checks++; if (bus.disparity_out !== 12'(EXP_D6)) begin failures++; $display("FAIL b2b_disp got=%0d exp=%0d", bus.disparity_out, EXP_D6); end
    checks++; if (bus.x_2_out !== 12'(EXP_X6)) begin failures++; $display("FAIL b2b_x2 got=%0d exp=%0d", bus.x_2_out, EXP_X6); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    send(8'd12, 12'd640);
    repeat (7) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    checks++; if (bus.disparity_out !== 12'd0) begin failures++; $display("FAIL rstmid_disp got=%0d exp=0", bus.disparity_out); end
    checks++; if (bus.x_2_out !== 12'd0) begin failures++; $display("FAIL rstmid_x2 got=%0d exp=0", bus.x_2_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk_in);
      if (bus.data_valid_out === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_valid got=%b exp=0", seen); end
    send(8'd255, 12'd1279);
    wait_valid(lat);
    checks++; if (lat !== 17) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=17", lat); end
    checks++; if (bus.disparity_out !== 12'(EXP_D255)) begin failures++; $display("FAIL rstmid_next_disp got=%0d exp=%0d", bus.disparity_out, EXP_D255); end
  endtask

  initial begin
    bus.data_valid_in = 1'b0;
    bus.depth_in      = '0;
    bus.x_1_in        = '0;
    test_reset();
    test_basic();
    test_far();
    test_clamp();
    test_depth_zero();
    test_busy_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
